// File: rtl/player_input_pkg.sv
// Shared types and defaults for the two-player button front end.
// Holds the per-key debounce FSM encoding and the default debounce length.
package player_input_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    KEY_IDLE         = 2'd0,
    KEY_PRESS_WAIT   = 2'd1,
    KEY_HELD         = 2'd2,
    KEY_RELEASE_WAIT = 2'd3
  } key_state_t;

endpackage

// File: rtl/player_input_if.sv
// Button/enable inputs and press-pulse outputs of the player input block.
// master drives keys and enable, slave (the block) drives the pulses.
interface player_input_if;
  logic key_l;
  logic key_r;
  logic enable;
  logic L;
  logic R;

  modport master (output key_l, output key_r, output enable, input L, input R);
  modport slave  (input key_l, input key_r, input enable, output L, output R);
endinterface

// File: rtl/key_conditioner.sv
// One key: 2-flop synchronizer, debounce FSM with counter, registered press pulse.
// Pulse is high the cycle after PRESS_WAIT->HELD, only if en was 1 at that edge.
module key_conditioner
  import player_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  input  logic en,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          s;
  key_state_t    state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= key;
      s     <= sync1;
    end
  end

  // cnt is cleared on every exit from a wait state, so it never exceeds LAST.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= KEY_IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      case (state)
        KEY_IDLE: begin
          if (s) begin
            state <= KEY_PRESS_WAIT;
            cnt   <= '0;
          end
        end
        KEY_PRESS_WAIT: begin
          if (!s) begin
            state <= KEY_IDLE;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= KEY_HELD;
            cnt   <= '0;
            pulse <= en;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        KEY_HELD: begin
          if (!s) begin
            state <= KEY_RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        KEY_RELEASE_WAIT: begin
          if (s) begin
            state <= KEY_HELD;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= KEY_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= KEY_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/player_input.sv
// Left/right player buttons to one-cycle press pulses; each key debounced independently.
// Enable is sampled at the accept edge, so a press finished while disabled is swallowed.
module player_input
  import player_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic     clk,
  input  logic     reset,
  player_input_if.slave pi
);

  key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_l (
    .clk   (clk),
    .reset (reset),
    .key   (pi.key_l),
    .en    (pi.enable),
    .pulse (pi.L)
  );

  key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_r (
    .clk   (clk),
    .reset (reset),
    .key   (pi.key_r),
    .en    (pi.enable),
    .pulse (pi.R)
  );

endmodule

// File: tb/tb_player_input.sv
// Directed vector table plus randomized run against a run-length debounce model.
module tb_player_input;

  localparam int D = 4;
  localparam int P = D + 2;   // table index of the pulse after a clean press from idle

  typedef struct {
    logic rst;
    logic kl;
    logic kr;
    logic en;
    logic el;
    logic er;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  vec_t tbl[$];

  // model: synchronizer pipeline, debounced level, run of samples disagreeing with it
  logic m_s1 [2];
  logic m_s  [2];
  logic m_db [2];
  int   m_run[2];
  logic m_p  [2];

  player_input_if pi();

  player_input #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .reset (reset),
    .pi    (pi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_s1[i] = 1'b0; m_s[i] = 1'b0; m_db[i] = 1'b0; m_run[i] = 0; m_p[i] = 1'b0;
    end
  endtask

  // A key's debounced level flips after D+1 consecutive synchronized samples
  // that disagree with it; a rising flip with enable set yields a pulse.
  task automatic model_edge(input logic kl, input logic kr, input logic en);
    logic k[2];
    k[0] = kl; k[1] = kr;
    for (int i = 0; i < 2; i++) begin
      m_p[i] = 1'b0;
      if (m_s[i] != m_db[i]) begin
        m_run[i]++;
        if (m_run[i] == D + 1) begin
          m_db[i]  = m_s[i];
          m_run[i] = 0;
          m_p[i]   = m_s[i] & en;
        end
      end else begin
        m_run[i] = 0;
      end
      m_s[i]  = m_s1[i];
      m_s1[i] = k[i];
    end
  endtask

  task automatic tick(input logic rst, input logic kl, input logic kr, input logic en);
    @(negedge clk);
    reset    = rst;
    pi.key_l = kl;
    pi.key_r = kr;
    pi.enable = en;
    if (!rst) model_reset();
    @(posedge clk);
    if (rst) model_edge(kl, kr, en);
    #1;
    chk("model_L", pi.L, m_p[0]);
    chk("model_R", pi.R, m_p[1]);
  endtask

  task automatic add_rep(input logic rst, input logic kl, input logic kr, input logic en,
                         input int n, input int pl, input int pr);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.rst = rst; v.kl = kl; v.kr = kr; v.en = en;
      v.el = (i == pl); v.er = (i == pr);
      tbl.push_back(v);
    end
  endtask

  initial begin
    logic kl, kr, en, rst;
    checks = 0;
    errors = 0;
    reset = 1'b0;
    pi.key_l = 1'b0; pi.key_r = 1'b0; pi.enable = 1'b1;
    model_reset();

    // reset with keys held, release -> one pulse each
    add_rep(0, 1, 1, 1, 3, -1, -1);
    add_rep(1, 1, 1, 1, 10, P, P);
    add_rep(1, 0, 0, 1, 8, -1, -1);
    // clean left press held 20 cycles
    add_rep(1, 1, 0, 1, 20, P, -1);
    add_rep(1, 0, 0, 1, 8, -1, -1);
    // bounce then steady press
    add_rep(1, 1, 0, 1, 2, -1, -1);
    add_rep(1, 0, 0, 1, 1, -1, -1);
    add_rep(1, 1, 0, 1, 2, -1, -1);
    add_rep(1, 0, 0, 1, 5, -1, -1);
    add_rep(1, 1, 0, 1, 10, P, -1);
    add_rep(1, 0, 0, 1, 8, -1, -1);
    // simultaneous press
    add_rep(1, 1, 1, 1, 10, P, P);
    add_rep(1, 0, 0, 1, 8, -1, -1);
    // press consumed while disabled, enable while held, release, press again
    add_rep(1, 0, 1, 0, 10, -1, -1);
    add_rep(1, 0, 1, 1, 5, -1, -1);
    add_rep(1, 0, 0, 1, 6, -1, -1);
    add_rep(1, 0, 1, 1, 10, -1, P);
    add_rep(1, 0, 0, 1, 8, -1, -1);
    // reset during PRESS_WAIT with cnt=2, key held through release
    add_rep(1, 1, 0, 1, 5, -1, -1);
    add_rep(0, 1, 0, 1, 3, -1, -1);
    add_rep(1, 1, 0, 1, 10, P, -1);
    add_rep(1, 0, 0, 1, 8, -1, -1);

    foreach (tbl[i]) begin
      tick(tbl[i].rst, tbl[i].kl, tbl[i].kr, tbl[i].en);
      chk("vec_L", pi.L, tbl[i].el);
      chk("vec_R", pi.R, tbl[i].er);
    end

    // randomized: slow-toggling keys with glitches, wandering enable, rare resets
    kl = 1'b0; kr = 1'b0; en = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 7) == 0) kl = ~kl;
      if ($urandom_range(0, 7) == 0) kr = ~kr;
      if ($urandom_range(0, 19) == 0) en = ~en;
      rst = ($urandom_range(0, 199) != 0);
      tick(rst, kl, kr, en);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/player_input.md
PLAYER_INPUT -- requirements
Module: player_input

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive synchronized-stable cycles required to accept a press or release (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit, meaning the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, meaning asynchronous active-low reset (asserted when 0).
REQ-004 The block SHALL have port key_l, input, 1 bit, meaning raw asynchronous left-player button (1 = pressed).
REQ-005 The block SHALL have port key_r, input, 1 bit, meaning raw asynchronous right-player button (1 = pressed).
REQ-006 The block SHALL have port enable, input, 1 bit, meaning 1 permits press pulses and 0 suppresses them (game over or halted).
REQ-007 The block SHALL have port L, output, 1 bit, meaning one-cycle left-press pulse that drives the playfield lights.
REQ-008 The block SHALL have port R, output, 1 bit, meaning one-cycle right-press pulse that drives the playfield lights.

Function
REQ-009 Each key SHALL pass through a two-flop synchronizer; only the second flop (s) SHALL feed the control logic.
REQ-010 Each key SHALL have an independent 4-state FSM: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT, plus a counter cnt of width $clog2(DEBOUNCE_CYCLES+1).
REQ-011 IDLE SHALL go to PRESS_WAIT with cnt=0 on s=1, and SHALL stay in IDLE on s=0.
REQ-012 PRESS_WAIT SHALL go to IDLE on s=0, go to HELD on s=1 with cnt==DEBOUNCE_CYCLES-1, and otherwise increment cnt.
REQ-013 HELD SHALL go to RELEASE_WAIT with cnt=0 on s=0, and SHALL stay in HELD on s=1.
REQ-014 RELEASE_WAIT SHALL return to HELD on s=1 with no pulse, go to IDLE on s=0 with cnt==DEBOUNCE_CYCLES-1, and otherwise increment cnt.
REQ-015 The pulse SHALL be registered: L (or R) SHALL be 1 for exactly the one cycle following the PRESS_WAIT->HELD edge, and only if enable=1 at that edge.
REQ-016 Latency: with the raw key rising before edge 1 and held steady, s=1 after edge 2, PRESS_WAIT after edge 3, and the pulse SHALL be high in the cycle after edge 3+DEBOUNCE_CYCLES (edge 7 for the default).
REQ-017 Holding a key indefinitely SHALL produce exactly one pulse; a new pulse SHALL require a full debounced release back to IDLE.
REQ-018 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles in either direction SHALL produce no pulse and no extra pulse.
REQ-019 Simultaneous qualifying L and R presses SHALL pulse both outputs in the same cycle; no arbitration, because the light stage treats L&R as no move.
REQ-020 enable=0 SHALL NOT freeze the FSMs; a press completing while disabled SHALL be consumed (reach HELD) with no later pulse.
REQ-021 The counter SHALL never wrap; it SHALL be compared and cleared before reaching 2^width-1.

Reset
REQ-022 While reset=0, the synchronizer flops SHALL be 0, both FSMs SHALL be IDLE, cnt SHALL be 0, and L=R=0, all asynchronously.
REQ-023 Reset asserted mid-debounce or mid-hold SHALL discard progress; after deassertion, a still-held key SHALL be re-debounced from IDLE and SHALL yield one pulse.

Structure
REQ-024 A shared package SHALL hold the key FSM state enum (2-bit) and the default DEBOUNCE_CYCLES constant.
REQ-025 One sub-module, key_conditioner (synchronizer, FSM, counter and pulse register for one key), SHALL be instantiated twice; player_input SHALL only apply enable gating and wiring.

Verification
REQ-026 The bench SHALL cover reset: reset=0, keys=1 -> L=R=0; release reset with keys held -> exactly one pulse each at edge 7 after release.
REQ-027 The bench SHALL cover a clean press: key_l 0->1 held 20 cycles, enable=1 -> L=1 for exactly one cycle, 7 cycles after the first sampling edge, R=0 throughout.
REQ-028 The bench SHALL cover a bounce: key_l high 2 cycles, low 1, high 2, low -> no L pulse; then steady high 10 cycles -> exactly one L pulse.
REQ-029 The bench SHALL cover a simultaneous press: key_l and key_r rise together -> L=1 and R=1 in the same single cycle.
REQ-030 The bench SHALL cover enable gating: enable=0, press and hold key_r -> no R pulse; set enable=1 while held -> still no pulse; release 6 cycles, press again -> one R pulse.
REQ-031 The bench SHALL cover reset mid-operation: reset=0 during PRESS_WAIT (cnt=2) -> no pulse; key held through reset release -> one pulse at edge 7 after release.
